// File: rtl/hdmi_tx_stream_pkg.sv
// Shared HDMI definitions: default 640x480 timing, TMDS control symbols,
// pipeline flag bundle and the receive-side decoder constants.
package hdmi_tx_stream_pkg;

  // Default 640x480@60 timing (pixels / lines)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int COORD_W = 12;

  // Control-period symbols, indexed by ctrl = {c1, c0}
  localparam logic [9:0] CTRL_SYM_00 = 10'h354;
  localparam logic [9:0] CTRL_SYM_01 = 10'h0AB;
  localparam logic [9:0] CTRL_SYM_10 = 10'h154;
  localparam logic [9:0] CTRL_SYM_11 = 10'h2AB;

  // Receive side: one register stage from symbol to decoded byte
  localparam int TMDS_DEC_LATENCY = 1;

  // Sync/active flags travelling alongside the pixel pipeline
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } line_flags_t;

  function automatic logic [9:0] ctrl_symbol(input logic [1:0] ctrl);
    case (ctrl)
      2'b00:   return CTRL_SYM_00;
      2'b01:   return CTRL_SYM_01;
      2'b10:   return CTRL_SYM_10;
      default: return CTRL_SYM_11;
    endcase
  endfunction

  // Receive side: recover ctrl bits from a control symbol
  function automatic logic [1:0] ctrl_decode(input logic [9:0] sym);
    case (sym)
      CTRL_SYM_01: return 2'b01;
      CTRL_SYM_10: return 2'b10;
      CTRL_SYM_11: return 2'b11;
      default:     return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] count_ones(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

endpackage

// File: rtl/hdmi_tx_stream_encoder.sv
// DVI 8b10b TMDS encoder for one channel: transition-minimise stage,
// DC-balance stage against a signed 5-bit running disparity, registered symbol.
// The disparity is cleared on every control-period cycle.
module tmds_8b10b_encoder
  import hdmi_tx_stream_pkg::*;
(
  input  logic       hdmi_clk,
  input  logic       reset,
  input  logic       de,
  input  logic [1:0] ctrl,
  input  logic [7:0] data,
  output logic [9:0] symbol
);

  logic [3:0]        n1_data;
  logic              use_xnor;
  logic              acc;
  logic [8:0]        q_m;
  logic [3:0]        n1_qm;
  logic signed [5:0] bal_wide;
  logic signed [4:0] bal;
  logic signed [4:0] disparity;
  logic signed [4:0] disparity_nxt;
  logic [9:0]        symbol_nxt;

  // Transition-minimise: chain XOR or XNOR, whichever gives fewer transitions
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    q_m      = '0;
    n1_data  = count_ones(data);
    use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data[0]);
    acc      = data[0];
    q_m[0]   = acc;
    for (int i = 1; i < 8; i++) begin
      acc    = use_xnor ? ~(acc ^ data[i]) : (acc ^ data[i]);
      q_m[i] = acc;
    end
    q_m[8] = ~use_xnor;
  end

  // DC balance: choose inversion from current disparity and word imbalance
  always_comb begin
    n1_qm         = count_ones(q_m[7:0]);
    bal_wide      = $signed({1'b0, n1_qm, 1'b0}) - 6'sd8;  // ones - zeros
    bal           = bal_wide[4:0];
    symbol_nxt    = {1'b0, q_m[8], q_m[7:0]};
    disparity_nxt = disparity;
    if ((disparity == 5'sd0) || (bal == 5'sd0)) begin
      symbol_nxt    = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
      disparity_nxt = q_m[8] ? (disparity + bal) : (disparity - bal);
    end else if ((!disparity[4] && (bal > 5'sd0)) || (disparity[4] && (bal < 5'sd0))) begin
      symbol_nxt    = {1'b1, q_m[8], ~q_m[7:0]};
      disparity_nxt = disparity + (q_m[8] ? 5'sd2 : 5'sd0) - bal;
    end else begin
      symbol_nxt    = {1'b0, q_m[8], q_m[7:0]};
      disparity_nxt = disparity - (q_m[8] ? 5'sd0 : 5'sd2) + bal;
    end
  end

  // Symbol and disparity registers; control periods restart the balance from 0
  always_ff @(posedge hdmi_clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!reset) begin
      symbol    <= CTRL_SYM_00;
      disparity <= '0;
    end else if (!de) begin
      symbol    <= ctrl_symbol(ctrl);
      disparity <= '0;
    end else begin
      symbol    <= symbol_nxt;
      disparity <= disparity_nxt;
    end
  end

endmodule

// File: rtl/hdmi_tx_stream.sv
// HDMI/DVI transmit stream: raster counters, pixel request, 2-cycle pipeline
// to three TMDS encoders (d0=blue, d1=green, d2=red) with aligned sync.
// Optional feature macro: HDMI_TX_TEST_PATTERN_EN replaces r/g/b with 8
// vertical colour bars (bar k = {r=k[2], g=k[1], b=k[0]} at full scale).
module hdmi_tx_stream
  import hdmi_tx_stream_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic               hdmi_clk,
  input  logic               reset,
  output logic [COORD_W-1:0] xaddr,
  output logic [COORD_W-1:0] yaddr,
  output logic               rgb_req,
  input  logic [7:0]         r,
  input  logic [7:0]         g,
  input  logic [7:0]         b,
  output logic               hsync,
  output logic               vsync,
  output logic [9:0]         tmds_d0,
  output logic [9:0]         tmds_d1,
  output logic [9:0]         tmds_d2
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [COORD_W-1:0] h;
  logic [COORD_W-1:0] v;
  logic               running;
  logic               active;
  line_flags_t        now_flags;
  line_flags_t        stage1;
  logic [7:0]         pix_r;
  logic [7:0]         pix_g;
  logic [7:0]         pix_b;

  // Raster counters; the first cycle after reset holds (0,0) so it is presented once
  always_ff @(posedge hdmi_clk) begin
    if (!reset) begin
      h       <= '0;
      v       <= '0;
      running <= 1'b0;
    end else if (!running) begin
      running <= 1'b1;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign active          = running && (h < H_ACT_C) && (v < V_ACT_C);
  assign now_flags.de    = active;
  assign now_flags.hsync = (h >= HS_START) && (h < HS_END);
  assign now_flags.vsync = (v >= VS_START) && (v < VS_END);

  assign xaddr   = h;
  assign yaddr   = v;
  assign rgb_req = active;

  // First delay stage: flags wait one cycle for the pixel data to return
  always_ff @(posedge hdmi_clk) begin
    if (!reset) stage1 <= '0;
    else        stage1 <= now_flags;
  end

  // Second delay stage for sync, matching the encoder output register
  always_ff @(posedge hdmi_clk) begin
    if (!reset) begin
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      hsync <= stage1.hsync;
      vsync <= stage1.vsync;
    end
  end

`ifdef HDMI_TX_TEST_PATTERN_EN
  localparam logic [COORD_W-1:0] BAR_W = COORD_W'(H_ACTIVE / 8);

  logic [COORD_W-1:0] x_d1;
  logic [2:0]         bar;
  logic               unused_pixel_in;

  // Column delayed to line up with the cycle in which pixel data would return
  always_ff @(posedge hdmi_clk) begin
    if (!reset) x_d1 <= '0;
    else        x_d1 <= h;
  end

  assign bar             = 3'(x_d1 / BAR_W);
  assign pix_r           = bar[2] ? 8'hFF : 8'h00;
  assign pix_g           = bar[1] ? 8'hFF : 8'h00;
  assign pix_b           = bar[0] ? 8'hFF : 8'h00;
  assign unused_pixel_in = ^{r, g, b};
`else
  assign pix_r = r;
  assign pix_g = g;
  assign pix_b = b;
`endif

  tmds_8b10b_encoder u_enc_blue (
    .hdmi_clk (hdmi_clk),
    .reset    (reset),
    .de       (stage1.de),
    .ctrl     ({stage1.vsync, stage1.hsync}),
    .data     (pix_b),
    .symbol   (tmds_d0)
  );

  tmds_8b10b_encoder u_enc_green (
    .hdmi_clk (hdmi_clk),
    .reset    (reset),
    .de       (stage1.de),
    .ctrl     (2'b00),
    .data     (pix_g),
    .symbol   (tmds_d1)
  );

  tmds_8b10b_encoder u_enc_red (
    .hdmi_clk (hdmi_clk),
    .reset    (reset),
    .de       (stage1.de),
    .ctrl     (2'b00),
    .data     (pix_r),
    .symbol   (tmds_d2)
  );

endmodule

// File: tb/tb_hdmi_tx_stream.sv
// Directed bench for hdmi_tx_stream on a reduced raster (88 x 13) so that
// whole frames fit in the cycle budget; symbols are checked by DVI decode.
`timescale 1ns/1ps
module tb_hdmi_tx_stream;

  localparam int HA = 64, HF = 4, HS = 12, HB = 8;
  localparam int VA = 6,  VF = 2, VS = 2,  VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        hdmi_clk = 1'b0;
  logic        reset    = 1'b0;
  logic [11:0] xaddr, yaddr;
  logic        rgb_req;
  logic [7:0]  r = '0, g = '0, b = '0;
  logic        hsync, vsync;
  logic [9:0]  tmds_d0, tmds_d1, tmds_d2;

  int n_cmp = 0;
  int n_bad = 0;

  hdmi_tx_stream #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .hdmi_clk (hdmi_clk),
    .reset    (reset),
    .xaddr    (xaddr),
    .yaddr    (yaddr),
    .rgb_req  (rgb_req),
    .r        (r),
    .g        (g),
    .b        (b),
    .hsync    (hsync),
    .vsync    (vsync),
    .tmds_d0  (tmds_d0),
    .tmds_d1  (tmds_d1),
    .tmds_d2  (tmds_d2)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  // One raster position as seen by the bench model, with the data it was given
  typedef struct {
    bit          valid;
    int          h;
    int          v;
    logic [23:0] rgb;
  } slot_t;

  slot_t       m1, m2;
  bit          running = 1'b0;
  int          bh = 0, bv = 0;
  logic [23:0] rgb_cur = '0;
  int          src_mode = 0;
  logic [23:0] src_const = '0;

  function automatic bit in_hs(int h);
    return (h >= HA + HF) && (h < HA + HF + HS);
  endfunction

  function automatic bit in_vs(int v);
    return (v >= VA + VF) && (v < VA + VF + VS);
  endfunction

  function automatic bit is_data(slot_t s);
    return s.valid && (s.h < HA) && (s.v < VA);
  endfunction

  function automatic logic [9:0] ctrl_code(logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  function automatic logic [7:0] decode(logic [9:0] s);
    logic [7:0] d, q;
    d = s[9] ? ~s[7:0] : s[7:0];
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return q;
  endfunction

  // Expected {r,g,b} for a pixel
  function automatic logic [23:0] exp_pixel(slot_t s);
`ifdef HDMI_TX_TEST_PATTERN_EN
    int k;
    k = s.h / (HA / 8);
    return {(k[2] ? 8'hFF : 8'h00), (k[1] ? 8'hFF : 8'h00), (k[0] ? 8'hFF : 8'h00)};
`else
    return s.rgb;
`endif
  endfunction

  // Step one clock: update the raster model, return pixel data for last request
  task automatic advance();
    logic  rst_seen;
    slot_t prev;
    rst_seen = reset;
    @(posedge hdmi_clk);
    #1;
    prev.valid = running;
    prev.h     = bh;
    prev.v     = bv;
    prev.rgb   = rgb_cur;
    m2 = m1;
    m1 = prev;
    if (!rst_seen) begin
      m1.valid = 1'b0;
      m2.valid = 1'b0;
      running  = 1'b0;
      bh = 0;
      bv = 0;
    end else if (!running) begin
      running = 1'b1;
      bh = 0;
      bv = 0;
    end else if (bh == HT - 1) begin
      bh = 0;
      bv = (bv == VT - 1) ? 0 : bv + 1;
    end else begin
      bh++;
    end
    {r, g, b} = m1.rgb;
    rgb_cur = (src_mode == 1) ? 24'($urandom) : src_const;
  endtask

  task automatic test_reset();
    src_mode  = 0;
    src_const = 24'h000000;
    rgb_cur   = '0;
    m1.valid  = 1'b0;
    m2.valid  = 1'b0;
    reset     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      advance();
      n_cmp++;
      if (xaddr !== 12'd0 || yaddr !== 12'd0 || rgb_req !== 1'b0 || hsync !== 1'b0 || vsync !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_ctrl: got x=%0d y=%0d req=%b hs=%b vs=%b, expected all 0", xaddr, yaddr, rgb_req, hsync, vsync);
      end
      n_cmp++;
      if ({tmds_d0, tmds_d1, tmds_d2} !== {10'h354, 10'h354, 10'h354}) begin
        n_bad++;
        $display("FAIL reset_tmds: got %h %h %h, expected 354 354 354", tmds_d0, tmds_d1, tmds_d2);
      end
    end
    reset = 1'b1;
    advance();
    n_cmp++;
    if (rgb_req !== 1'b1 || xaddr !== 12'd0 || yaddr !== 12'd0) begin
      n_bad++;
      $display("FAIL first_req: got req=%b x=%0d y=%0d, expected req=1 x=0 y=0", rgb_req, xaddr, yaddr);
    end
    n_cmp++;
    if (tmds_d0 !== 10'h354) begin
      n_bad++;
      $display("FAIL cycle0_d0: got %h, expected 354", tmds_d0);
    end
    advance();
    n_cmp++;
    if (tmds_d0 !== 10'h354) begin
      n_bad++;
      $display("FAIL cycle1_d0: got %h, expected 354", tmds_d0);
    end
    advance();
    n_cmp++;
    if ({tmds_d0, tmds_d1, tmds_d2} !== {10'h100, 10'h100, 10'h100}) begin
      n_bad++;
      $display("FAIL zero_first: got %h %h %h, expected 100 100 100", tmds_d0, tmds_d1, tmds_d2);
    end
    advance();
    n_cmp++;
    if ({tmds_d0, tmds_d1, tmds_d2} !== {10'h3FF, 10'h3FF, 10'h3FF}) begin
      n_bad++;
      $display("FAIL zero_second: got %h %h %h, expected 3FF 3FF 3FF", tmds_d0, tmds_d1, tmds_d2);
    end
  endtask

  // Two 0xFF pixels at the start of line 1
  task automatic test_ff_pair();
    int         k;
    logic [9:0] e0, e1;
`ifdef HDMI_TX_TEST_PATTERN_EN
    e0 = 10'h100;
    e1 = 10'h3FF;
`else
    e0 = 10'h200;
    e1 = 10'h0FF;
`endif
    src_mode  = 0;
    src_const = 24'hFFFFFF;
    k = 0;
    while (!(m2.valid && m2.h == 0 && m2.v == 1) && k < 2 * HT) begin
      advance();
      k++;
    end
    n_cmp++;
    if (!(m2.valid && m2.h == 0 && m2.v == 1)) begin
      n_bad++;
      $display("FAIL ff_wait: line 1 start not reached within %0d cycles", 2 * HT);
    end
    n_cmp++;
    if ({tmds_d0, tmds_d1, tmds_d2} !== {e0, e0, e0}) begin
      n_bad++;
      $display("FAIL ff_first: got %h %h %h, expected %h on all", tmds_d0, tmds_d1, tmds_d2, e0);
    end
    advance();
    n_cmp++;
    if ({tmds_d0, tmds_d1, tmds_d2} !== {e1, e1, e1}) begin
      n_bad++;
      $display("FAIL ff_second: got %h %h %h, expected %h on all", tmds_d0, tmds_d1, tmds_d2, e1);
    end
  endtask

  // One full frame, every cycle checked against the raster model
  task automatic test_frame();
    int          k, hs_cnt, vs_cnt, req_cnt, line_cnt, hs_only_cnt, both_cnt;
    logic        e_hs, e_vs, e_req;
    logic [23:0] px, got;
    src_mode = 1;
    k = 0;
    while (!(bh == 0 && bv == 0) && k < 2 * HT * VT) begin
      advance();
      k++;
    end
    n_cmp++;
    if (!(bh == 0 && bv == 0)) begin
      n_bad++;
      $display("FAIL frame_wait: frame start not reached");
    end
    hs_cnt = 0; vs_cnt = 0; req_cnt = 0; line_cnt = 0; hs_only_cnt = 0; both_cnt = 0;
    for (int c = 0; c < HT * VT; c++) begin
      e_req = (bh < HA) && (bv < VA);
      e_hs  = m2.valid && in_hs(m2.h);
      e_vs  = m2.valid && in_vs(m2.v);
      n_cmp++;
      if (xaddr !== 12'(bh) || yaddr !== 12'(bv) || rgb_req !== e_req) begin
        n_bad++;
        $display("FAIL frame_pos: got x=%0d y=%0d req=%b, expected x=%0d y=%0d req=%b", xaddr, yaddr, rgb_req, bh, bv, e_req);
      end
      n_cmp++;
      if (hsync !== e_hs || vsync !== e_vs) begin
        n_bad++;
        $display("FAIL frame_sync at h=%0d v=%0d: got hs=%b vs=%b, expected hs=%b vs=%b", m2.h, m2.v, hsync, vsync, e_hs, e_vs);
      end
      n_cmp++;
      if (is_data(m2)) begin
        px  = exp_pixel(m2);
        got = {decode(tmds_d2), decode(tmds_d1), decode(tmds_d0)};
        if (got !== px) begin
          n_bad++;
          $display("FAIL frame_pixel at x=%0d y=%0d: got rgb %h, expected %h", m2.h, m2.v, got, px);
        end
      end else if ({tmds_d0, tmds_d1, tmds_d2} !== {ctrl_code({e_vs, e_hs}), 10'h354, 10'h354}) begin
        n_bad++;
        $display("FAIL frame_ctrl at h=%0d v=%0d: got %h %h %h, expected %h 354 354", m2.h, m2.v, tmds_d0, tmds_d1, tmds_d2, ctrl_code({e_vs, e_hs}));
      end
      if (hsync === 1'b1) hs_cnt++;
      if (vsync === 1'b1) vs_cnt++;
      if (rgb_req === 1'b1) req_cnt++;
      if (xaddr === 12'd0) line_cnt++;
      if (hsync === 1'b1 && vsync === 1'b0 && {tmds_d0, tmds_d1, tmds_d2} === {10'h0AB, 10'h354, 10'h354}) hs_only_cnt++;
      if (hsync === 1'b1 && vsync === 1'b1 && tmds_d0 === 10'h2AB) both_cnt++;
      advance();
    end
    n_cmp++;
    if (hs_cnt != VT * HS || vs_cnt != VS * HT) begin
      n_bad++;
      $display("FAIL sync_width: got hs=%0d vs=%0d cycles, expected hs=%0d vs=%0d", hs_cnt, vs_cnt, VT * HS, VS * HT);
    end
    n_cmp++;
    if (req_cnt != HA * VA || line_cnt != VT) begin
      n_bad++;
      $display("FAIL frame_shape: got req=%0d lines=%0d, expected req=%0d lines=%0d", req_cnt, line_cnt, HA * VA, VT);
    end
    n_cmp++;
    if (hs_only_cnt != (VT - VS) * HS || both_cnt != VS * HS) begin
      n_bad++;
      $display("FAIL blank_codes: got 0AB=%0d 2AB=%0d, expected 0AB=%0d 2AB=%0d", hs_only_cnt, both_cnt, (VT - VS) * HS, VS * HS);
    end
  endtask

  // Random pixels: decode round trip and bounded running disparity per channel
  task automatic test_random_disparity();
    int          disp [3];
    logic [9:0]  sym [3];
    logic [23:0] px, got;
    src_mode = 1;
    disp = '{0, 0, 0};
    for (int c = 0; c < 27 * HT * VT; c++) begin
      if (is_data(m2)) begin
        px  = exp_pixel(m2);
        got = {decode(tmds_d2), decode(tmds_d1), decode(tmds_d0)};
        n_cmp++;
        if (got !== px) begin
          n_bad++;
          $display("FAIL rand_pixel at x=%0d y=%0d: got rgb %h, expected %h", m2.h, m2.v, got, px);
        end
        sym = '{tmds_d0, tmds_d1, tmds_d2};
        for (int ch = 0; ch < 3; ch++) disp[ch] += 2 * $countones(sym[ch]) - 10;
        n_cmp++;
        if (disp[0] > 10 || disp[0] < -10 || disp[1] > 10 || disp[1] < -10 || disp[2] > 10 || disp[2] < -10) begin
          n_bad++;
          $display("FAIL disparity at x=%0d y=%0d: got %0d %0d %0d, expected within +-10", m2.h, m2.v, disp[0], disp[1], disp[2]);
        end
      end else begin
        disp = '{0, 0, 0};
      end
      advance();
    end
  endtask

  // Reset at (30,3) for 3 cycles, then the raster restarts at (0,0)
  task automatic test_mid_reset();
    int          k;
    logic [23:0] px, got;
    src_mode = 1;
    k = 0;
    while (!(bh == 30 && bv == 3) && k < 2 * HT * VT) begin
      advance();
      k++;
    end
    n_cmp++;
    if (!(bh == 30 && bv == 3)) begin
      n_bad++;
      $display("FAIL mid_wait: (30,3) not reached");
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      advance();
      n_cmp++;
      if (xaddr !== 12'd0 || yaddr !== 12'd0 || rgb_req !== 1'b0 || hsync !== 1'b0 || vsync !== 1'b0 ||
          {tmds_d0, tmds_d1, tmds_d2} !== {10'h354, 10'h354, 10'h354}) begin
        n_bad++;
        $display("FAIL mid_reset: got x=%0d y=%0d req=%b hs=%b vs=%b tmds=%h %h %h, expected 0 0 0 0 0 354 354 354",
                 xaddr, yaddr, rgb_req, hsync, vsync, tmds_d0, tmds_d1, tmds_d2);
      end
    end
    reset = 1'b1;
    advance();
    n_cmp++;
    if (rgb_req !== 1'b1 || xaddr !== 12'd0 || yaddr !== 12'd0) begin
      n_bad++;
      $display("FAIL restart_pos: got req=%b x=%0d y=%0d, expected req=1 x=0 y=0", rgb_req, xaddr, yaddr);
    end
    advance();
    n_cmp++;
    if (tmds_d0 !== 10'h354) begin
      n_bad++;
      $display("FAIL restart_c1: got %h, expected 354", tmds_d0);
    end
    advance();
    px  = exp_pixel(m2);
    got = {decode(tmds_d2), decode(tmds_d1), decode(tmds_d0)};
    n_cmp++;
    if (got !== px || !(m2.h == 0 && m2.v == 0)) begin
      n_bad++;
      $display("FAIL restart_pixel: got rgb %h at model (%0d,%0d), expected %h at (0,0)", got, m2.h, m2.v, px);
    end
    for (int i = 0; i < 16; i++) begin
      advance();
      n_cmp++;
      if (xaddr !== 12'(bh) || yaddr !== 12'd0) begin
        n_bad++;
        $display("FAIL restart_count: got x=%0d y=%0d, expected x=%0d y=0", xaddr, yaddr, bh);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ff_pair();
    test_frame();
    test_random_disparity();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
